// File: rtl/scoreboard.sv
// Register-dependency scoreboard and issue controller between decode and
// execute. Tracks pending register writes, blocks issue on RAW/WAW hazards
// or when too many writes are outstanding, and runs a drain handshake.
module scoreboard #(
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_rs1_used,
  input  logic        issue_rs2_used,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  input  logic        retire_valid,
  input  logic [4:0]  retire_rd,
  input  logic        kill_valid,
  input  logic [4:0]  kill_rd,
  input  logic        drain_req,
  output logic        drain_ack,
  output logic [31:0] busy,
  output logic [3:0]  pending
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);
  localparam logic       BYP     = (BYPASS != 0);

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

  state_t      state;
  state_t      state_nxt;

  logic        ret_rel;
  logic        kill_rel;
  logic [31:0] rel_mask;
  logic [3:0]  rel_cnt;
  logic [31:0] busy_eff;
  logic [3:0]  pend_eff;
  logic        hazard;
  logic        full;
  logic        issue_fire;
  logic        issue_set;
  logic [31:0] set_mask;
  logic [31:0] busy_nxt;
  logic [3:0]  pend_nxt;

  // A release only counts when it names a busy, non-zero register; a kill
  // naming the same register as a retire is folded into the retire so the
  // count never goes below the number of busy bits.
  assign ret_rel  = retire_valid && (retire_rd != 5'd0) && busy[retire_rd];
  assign kill_rel = kill_valid && (kill_rd != 5'd0) && busy[kill_rd] &&
                    !(ret_rel && (kill_rd == retire_rd));
  assign rel_cnt  = {3'b000, ret_rel} + {3'b000, kill_rel};

  // Decode the releasing registers into a clear mask.
  always_comb begin
    rel_mask = '0;
    if (ret_rel)  rel_mask[retire_rd] = 1'b1;
    if (kill_rel) rel_mask[kill_rd]   = 1'b1;
  end

  // With bypass, same-cycle releases are visible to this cycle's issue check.
  assign busy_eff = BYP ? (busy & ~rel_mask) : busy;
  assign pend_eff = BYP ? (pending - rel_cnt) : pending;

  assign hazard = (issue_rs1_used && busy_eff[issue_rs1]) ||
                  (issue_rs2_used && busy_eff[issue_rs2]) ||
                  (issue_rd_we && (issue_rd != 5'd0) && busy_eff[issue_rd]);
  assign full   = (pend_eff == DEPTH_C);

  assign issue_ready = aresetn && (state == RUN) && !hazard && !full && !drain_req;
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_set   = issue_fire && issue_rd_we && (issue_rd != 5'd0);
  assign set_mask    = issue_set ? (32'd1 << issue_rd) : 32'd0;

  // Set wins over clear so an issue and release on the same rd leaves it busy.
  assign busy_nxt = ((busy & ~rel_mask) | set_mask) & 32'hFFFF_FFFE;
  assign pend_nxt = pending - rel_cnt + {3'b000, issue_set};

  assign drain_ack = (state == ACK);

  // Drain FSM next-state: DRAIN waits for every outstanding write to leave.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req) state_nxt = DRAIN;
      DRAIN:   if (pending == 4'd0) state_nxt = ACK;
      ACK:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State, busy flags and pending count; reset abandons any drain in progress.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state   <= RUN;
      busy    <= '0;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      pending <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: expected busy/pending values are queued
// when stimulus is driven and compared after the following clock edge.
module tb_scoreboard;

  localparam int DEPTH  = 4;
  localparam int BYPASS = 1;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_rs1_used;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_we;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        drain_req;
  logic        drain_ack;
  logic [31:0] busy;
  logic [3:0]  pending;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  string       qtag[$];
  logic [31:0] qbusy[$];
  logic [3:0]  qpend[$];

  scoreboard #(.DEPTH(DEPTH), .BYPASS(BYPASS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .drain_req(drain_req), .drain_ack(drain_ack),
    .busy(busy), .pending(pending)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] b, input logic [3:0] p);
    qtag.push_back(tag);
    qbusy.push_back(b);
    qpend.push_back(p);
  endtask

  task automatic pop_all();
    string t;
    while (qtag.size() > 0) begin
      t = qtag.pop_front();
      check({t, "_busy"}, busy, qbusy.pop_front());
      check({t, "_pend"}, {28'd0, pending}, {28'd0, qpend.pop_front()});
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_rd = 0; issue_rd_we = 0;
    retire_valid = 0; retire_rd = 0; kill_valid = 0; kill_rd = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic we);
    issue_valid = 1; issue_rs1 = rs1; issue_rs1_used = u1;
    issue_rs2 = rs2; issue_rs2_used = u2; issue_rd = rd; issue_rd_we = we;
  endtask

  // Occupancy bound and retire/kill protocol watch on every falling edge.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      checks++;
      assert (pending <= 4'(DEPTH)) passed++;
      else begin
        fails++;
        $error("FAIL pending_bound observed=%0d expected<=%0d", pending, DEPTH);
      end
    end
    if (retire_valid && kill_valid && retire_rd == kill_rd && retire_rd != 5'd0) begin
      checks++;
      fails++;
      $error("FAIL same_rd_release observed=%0d expected=distinct", retire_rd);
    end
  end

  initial begin
    idle();
    drain_req = 0;
    aresetn = 0;
    tick(); tick();
    // reset state
    check("rst_busy", busy, 32'd0);
    check("rst_pend", {28'd0, pending}, 32'd0);
    check("rst_ack", {31'd0, drain_ack}, 32'd0);
    check("rst_ready", {31'd0, issue_ready}, 32'd0);
    aresetn = 1; #1;
    check("run_ready", {31'd0, issue_ready}, 32'd1);

    // issue x5, then a RAW on x5 that a same-cycle retire unblocks
    issue(0, 0, 0, 0, 5, 1); #1;
    check("i5_ready", {31'd0, issue_ready}, 32'd1);
    push("i5", 32'h0000_0020, 1);
    tick(); idle(); pop_all();
    issue(5, 1, 0, 0, 6, 1); #1;
    check("raw5_ready", {31'd0, issue_ready}, 32'd0);
    retire_valid = 1; retire_rd = 5; #1;
    check("raw5_bypass_ready", {31'd0, issue_ready}, 32'd1);
    push("i6_r5", 32'h0000_0040, 1);
    tick(); idle(); pop_all();
    retire_valid = 1; retire_rd = 6;
    push("r6", 32'd0, 0);
    tick(); idle(); pop_all();

    // writes to x0, non-writing issue, releases that must be ignored
    issue(0, 0, 0, 0, 0, 1); push("i0", 32'd0, 0); tick(); idle(); pop_all();
    issue(0, 0, 0, 0, 9, 0); push("nowe", 32'd0, 0); tick(); idle(); pop_all();
    retire_valid = 1; retire_rd = 0; push("r0", 32'd0, 0); tick(); idle(); pop_all();
    kill_valid = 1; kill_rd = 10; push("k10_idle", 32'd0, 0); tick(); idle(); pop_all();

    // fill to DEPTH, then a kill frees a slot in the same cycle
    issue(0, 0, 0, 0, 1, 1); push("f1", 32'h0000_0002, 1); tick(); pop_all();
    issue(0, 0, 0, 0, 2, 1); push("f2", 32'h0000_0006, 2); tick(); pop_all();
    issue(0, 0, 0, 0, 3, 1); push("f3", 32'h0000_000E, 3); tick(); pop_all();
    issue(0, 0, 0, 0, 4, 1); push("f4", 32'h0000_001E, 4); tick(); pop_all();
    issue(0, 0, 0, 0, 6, 1); #1;
    check("full_ready", {31'd0, issue_ready}, 32'd0);
    kill_valid = 1; kill_rd = 3; #1;
    check("full_kill_ready", {31'd0, issue_ready}, 32'd1);
    push("i6_k3", 32'h0000_0056, 4);
    tick(); idle(); pop_all();
    // WAW on x4 is blocked
    issue(0, 0, 0, 0, 4, 1); #1;
    check("waw4_ready", {31'd0, issue_ready}, 32'd0);
    idle();
    kill_valid = 1; kill_rd = 6; push("k6", 32'h0000_0016, 3); tick(); idle(); pop_all();
    retire_valid = 1; retire_rd = 1; kill_valid = 1; kill_rd = 2;
    push("r1_k2", 32'h0000_0010, 1); tick(); idle(); pop_all();
    retire_valid = 1; retire_rd = 4; push("r4", 32'd0, 0); tick(); idle(); pop_all();

    // drain with x7, x8 outstanding
    issue(0, 0, 0, 0, 7, 1); push("i7", 32'h0000_0080, 1); tick(); pop_all();
    issue(0, 0, 0, 0, 8, 1); push("i8", 32'h0000_0180, 2); tick(); pop_all();
    issue(0, 0, 0, 0, 9, 1); drain_req = 1; #1;
    check("drreq_ready", {31'd0, issue_ready}, 32'd0);
    push("dr_noissue", 32'h0000_0180, 2);
    tick(); idle(); drain_req = 0; pop_all();
    check("dr_ready1", {31'd0, issue_ready}, 32'd0);
    retire_valid = 1; retire_rd = 7; push("dr_r7", 32'h0000_0100, 1); tick(); idle(); pop_all();
    check("dr_ack1", {31'd0, drain_ack}, 32'd0);
    retire_valid = 1; retire_rd = 8; push("dr_r8", 32'd0, 0); tick(); idle(); pop_all();
    check("dr_ack_p0", {31'd0, drain_ack}, 32'd0);
    check("dr_ready_p0", {31'd0, issue_ready}, 32'd0);
    tick();
    check("dr_ack", {31'd0, drain_ack}, 32'd1);
    check("dr_ready_ack", {31'd0, issue_ready}, 32'd0);
    tick();
    check("dr_ack_done", {31'd0, drain_ack}, 32'd0);
    check("dr_resume", {31'd0, issue_ready}, 32'd1);

    // drain_req held with nothing pending: 3-cycle ack period
    drain_req = 1; #1;
    check("hold_c0", {31'd0, drain_ack}, 32'd0);
    tick(); check("hold_c1", {31'd0, drain_ack}, 32'd0);
    tick(); check("hold_c2", {31'd0, drain_ack}, 32'd1);
    tick(); check("hold_c3", {31'd0, drain_ack}, 32'd0);
    tick(); check("hold_c4", {31'd0, drain_ack}, 32'd0);
    tick(); check("hold_c5", {31'd0, drain_ack}, 32'd1);
    drain_req = 0;
    tick(); check("hold_end_ready", {31'd0, issue_ready}, 32'd1);

    // reset in the middle of a drain
    issue(0, 0, 0, 0, 7, 1); push("m7", 32'h0000_0080, 1); tick(); pop_all();
    issue(0, 0, 0, 0, 8, 1); push("m8", 32'h0000_0180, 2); tick(); idle(); pop_all();
    drain_req = 1; tick(); drain_req = 0;
    aresetn = 0; #1;
    check("mrst_ready_low", {31'd0, issue_ready}, 32'd0);
    push("mrst", 32'd0, 0);
    tick(); pop_all();
    check("mrst_ack", {31'd0, drain_ack}, 32'd0);
    aresetn = 1; #1;
    check("mrst_ready", {31'd0, issue_ready}, 32'd1);
    tick(); check("mrst_noack1", {31'd0, drain_ack}, 32'd0);
    tick(); check("mrst_noack2", {31'd0, drain_ack}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
